// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: FSM state encoding and next-PC source select.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PcSelInc = 2'd0,
        PcSelBr  = 2'd1,
        PcSelJmp = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencer-side bundle: decoder flags, fetch/memory handshakes and PC register controls.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DISP_W = 8
) ();

    logic              run;
    logic [WIDTH-1:0]  pc_cur;
    logic              fetch_req;
    logic              fetch_ack;
    logic              ir_en;
    logic              op_jump;
    logic              op_branch;
    logic              cond_true;
    logic              op_mem;
    logic              op_load;
    logic              op_halt;
    logic [DISP_W-1:0] disp;
    logic [WIDTH-1:0]  jump_tgt;
    logic              mem_req;
    logic              mem_ack;
    logic              reg_we;
    logic              pc_en;
    logic [WIDTH-1:0]  pc_next;
    logic              halted;

    modport master (
        input  run, pc_cur, fetch_ack, op_jump, op_branch, cond_true, op_mem, op_load, op_halt,
               disp, jump_tgt, mem_ack,
        output fetch_req, ir_en, mem_req, reg_we, pc_en, pc_next, halted
    );

    modport slave (
        output run, pc_cur, fetch_ack, op_jump, op_branch, cond_true, op_mem, op_load, op_halt,
               disp, jump_tgt, mem_ack,
        input  fetch_req, ir_en, mem_req, reg_we, pc_en, pc_next, halted
    );

endinterface

// File: rtl/pc_sequencer_pc_next_mux.sv
// Next-PC datapath: increment, sign-extended relative branch, or absolute jump (all mod 2^WIDTH).
module pc_sequencer_pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DISP_W = 8
) (
    input  logic [WIDTH-1:0]  pc_cur_i,
    input  logic [DISP_W-1:0] disp_i,
    input  logic [WIDTH-1:0]  jump_tgt_i,
    input  pc_sel_e           sel_i,
    output logic [WIDTH-1:0]  pc_next_o
);

    logic [WIDTH-1:0] disp_sext;

    assign disp_sext = {{(WIDTH - DISP_W){disp_i[DISP_W-1]}}, disp_i};

    always_comb begin
        pc_next_o = pc_cur_i + WIDTH'(1);
        unique case (sel_i)
            PcSelBr:  pc_next_o = pc_cur_i + disp_sext;
            PcSelJmp: pc_next_o = jump_tgt_i;
            default:  pc_next_o = pc_cur_i + WIDTH'(1);
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer; sole driver of the PC register's load enable and load value.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     DISP_W    = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.master bus
);

    state_e            state_q, state_d;
    logic              fetch_req_q, fetch_req_d;
    logic              mem_req_q, mem_req_d;
    logic              halted_q, halted_d;
    logic              jump_q, jump_d;
    logic              branch_q, branch_d;
    logic              cond_q, cond_d;
    logic              load_q, load_d;
    logic [DISP_W-1:0] disp_q, disp_d;
    logic [WIDTH-1:0]  tgt_q, tgt_d;

    logic              ir_en;
    logic              pc_en;
    logic              reg_we;
    pc_sel_e           sel;
    logic [WIDTH-1:0]  mux_pc_next;

    always_comb begin
        state_d  = state_q;
        jump_d   = jump_q;
        branch_d = branch_q;
        cond_d   = cond_q;
        load_d   = load_q;
        disp_d   = disp_q;
        tgt_d    = tgt_q;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        reg_we   = 1'b0;
        sel      = PcSelInc;

        unique case (state_q)
            StIdle: begin
                if (bus.run) state_d = StFetch;
            end
            StFetch: begin
                ir_en = bus.fetch_ack;
                if (bus.fetch_ack) state_d = StDecode;
            end
            StDecode: begin
                jump_d   = bus.op_jump;
                branch_d = bus.op_branch;
                cond_d   = bus.cond_true;
                load_d   = bus.op_load;
                disp_d   = bus.disp;
                tgt_d    = bus.jump_tgt;
                if (bus.op_halt)     state_d = StHalt;
                else if (bus.op_mem) state_d = StMem;
                else                 state_d = StExec;
            end
            StExec: begin
                pc_en  = 1'b1;
                reg_we = !(jump_q || branch_q);
                // Jump outranks branch when the decoder flags both.
                if (jump_q)                  sel = PcSelJmp;
                else if (branch_q && cond_q) sel = PcSelBr;
                state_d = bus.run ? StFetch : StIdle;
            end
            StMem: begin
                if (bus.mem_ack) begin
                    pc_en   = 1'b1;
                    reg_we  = load_q;
                    state_d = bus.run ? StFetch : StIdle;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Request/status outputs are registered straight from the next state.
        fetch_req_d = (state_d == StFetch);
        mem_req_d   = (state_d == StMem);
        halted_d    = (state_d == StHalt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            fetch_req_q <= 1'b0;
            mem_req_q   <= 1'b0;
            halted_q    <= 1'b0;
            jump_q      <= 1'b0;
            branch_q    <= 1'b0;
            cond_q      <= 1'b0;
            load_q      <= 1'b0;
            disp_q      <= '0;
            tgt_q       <= '0;
        end else begin
            state_q     <= state_d;
            fetch_req_q <= fetch_req_d;
            mem_req_q   <= mem_req_d;
            halted_q    <= halted_d;
            jump_q      <= jump_d;
            branch_q    <= branch_d;
            cond_q      <= cond_d;
            load_q      <= load_d;
            disp_q      <= disp_d;
            tgt_q       <= tgt_d;
        end
    end

    pc_sequencer_pc_next_mux #(
        .WIDTH (WIDTH),
        .DISP_W(DISP_W)
    ) u_pc_next_mux (
        .pc_cur_i  (bus.pc_cur),
        .disp_i    (disp_q),
        .jump_tgt_i(tgt_q),
        .sel_i     (sel),
        .pc_next_o (mux_pc_next)
    );

    assign bus.fetch_req = fetch_req_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.halted    = halted_q;
    assign bus.ir_en     = ir_en;
    assign bus.pc_en     = pc_en;
    assign bus.reg_we    = reg_we;
    assign bus.pc_next   = (state_q == StIdle) ? RESET_VEC : mux_pc_next;

endmodule
